tilelink_ad_master: RTL

Single-outstanding TileLink-UL initiator (channel A requester, channel D consumer) that drives the RocketTile slave port `auto_anon_in_0_*` from a simple command/response interface. Used in formal and simulation harnesses to inject Get/PutFullData/PutPartialData traffic into the tile, for example into the DTIM. Also checks D-channel responses and flags protocol violations.

---
 rtl/tl_ul_pkg.sv | 19 +
 rtl/tilelink_ad_master.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/tl_ul_pkg.sv
// TileLink-UL opcode encodings and the state type shared by the A/D initiator.
package tl_ul_pkg;

  localparam logic [2:0] A_GET         = 3'd4;
  localparam logic [2:0] A_PUT_FULL    = 3'd0;
  localparam logic [2:0] A_PUT_PARTIAL = 3'd1;

  localparam logic [2:0] D_ACCESS_ACK      = 3'd0;
  localparam logic [2:0] D_ACCESS_ACK_DATA = 3'd1;
  localparam logic [2:0] D_HINT_ACK        = 3'd2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_RESP,
    ST_LERR
  } state_e;

endpackage

// File: rtl/tilelink_ad_master.sv
// Single-outstanding TileLink-UL initiator: turns one command into an A request,
// forwards D beats to the response port and flags D-channel protocol violations.
//
// state | meaning
// IDLE  | cmd_ready high, waiting for a command
// REQ   | a_valid high with registered fields until a_ready
// RESP  | D beats passed through to rsp_*, counting beats and idle cycles
// LERR  | locally rejected command, one error response beat, no A traffic
module tilelink_ad_master
  import tl_ul_pkg::*;
#(
  parameter int         XLEN      = 32,
  parameter logic [4:0] SOURCE_ID = 5'd0,
  parameter logic [7:0] TIMEOUT   = 8'd255,
  localparam int        BYTES     = XLEN / 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_opcode,
  input  logic [31:0]      cmd_address,
  input  logic [2:0]       cmd_size,
  input  logic [BYTES-1:0] cmd_mask,
  input  logic [XLEN-1:0]  cmd_data,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [XLEN-1:0]  rsp_data,
  output logic             rsp_error,
  output logic             rsp_last,
  input  logic             a_ready,
  output logic             a_valid,
  output logic [2:0]       a_bits_opcode,
  output logic [2:0]       a_bits_param,
  output logic [2:0]       a_bits_size,
  output logic [4:0]       a_bits_source,
  output logic [31:0]      a_bits_address,
  output logic [BYTES-1:0] a_bits_mask,
  output logic [XLEN-1:0]  a_bits_data,
  output logic             d_ready,
  input  logic             d_valid,
  input  logic [2:0]       d_bits_opcode,
  input  logic [1:0]       d_bits_param,
  input  logic [2:0]       d_bits_size,
  input  logic [4:0]       d_bits_source,
  input  logic             d_bits_sink,
  input  logic [XLEN-1:0]  d_bits_data,
  input  logic             d_bits_error,
  output logic             protocol_err
);

  localparam logic [2:0] BEAT_LG = 3'($clog2(BYTES));

  state_e             state_q, state_d;
  logic [2:0]         op_opcode_q, op_opcode_d;
  logic [2:0]         op_size_q, op_size_d;
  logic [31:0]        op_address_q, op_address_d;
  logic [BYTES-1:0]   op_mask_q, op_mask_d;
  logic [XLEN-1:0]    op_data_q, op_data_d;
  logic [3:0]         beat_cnt_q, beat_cnt_d;
  logic [7:0]         tmo_cnt_q, tmo_cnt_d;
  logic               protocol_err_q, protocol_err_d;

  logic        cmd_fire, a_fire, d_fire, cmd_illegal, cmd_is_put, op_is_get, beat_is_last;
  logic [31:0] align_mask;
  logic [7:0]  last_idx;
  logic [2:0]  exp_d_opcode;
  logic        unused_d_fields;

  assign unused_d_fields = ^{d_bits_param, d_bits_sink};

  assign cmd_ready = (state_q == ST_IDLE) && !reset;
  assign a_valid   = (state_q == ST_REQ) && !reset;
  assign d_ready   = (state_q == ST_RESP) && rsp_ready && !reset;

  assign cmd_fire = cmd_valid && cmd_ready;
  assign a_fire   = a_valid && a_ready;
  assign d_fire   = d_valid && d_ready;

  assign a_bits_opcode  = op_opcode_q;
  assign a_bits_param   = 3'd0;
  assign a_bits_size    = op_size_q;
  assign a_bits_source  = SOURCE_ID;
  assign a_bits_address = op_address_q;
  assign a_bits_mask    = op_mask_q;
  assign a_bits_data    = op_data_q;

  assign align_mask  = (32'd1 << cmd_size) - 32'd1;
  assign cmd_is_put  = (cmd_opcode == A_PUT_FULL) || (cmd_opcode == A_PUT_PARTIAL);
  assign cmd_illegal = !(cmd_is_put || (cmd_opcode == A_GET))
                    || (|(cmd_address & align_mask))
                    || (cmd_is_put && (cmd_size > BEAT_LG));

  // Multi-beat only for Gets larger than one bus word.
  assign op_is_get    = (op_opcode_q == A_GET);
  assign last_idx     = (op_is_get && (op_size_q > BEAT_LG))
                      ? (8'd1 << (op_size_q - BEAT_LG)) - 8'd1 : 8'd0;
  assign beat_is_last = ({4'd0, beat_cnt_q} == last_idx);
  assign exp_d_opcode = op_is_get ? D_ACCESS_ACK_DATA : D_ACCESS_ACK;

  always_comb begin
    rsp_valid = 1'b0;
    rsp_data  = '0;
    rsp_error = 1'b0;
    rsp_last  = 1'b0;
    if (!reset && (state_q == ST_RESP) && d_valid) begin
      rsp_valid = 1'b1;
      rsp_data  = d_bits_data;
      rsp_error = d_bits_error;
      rsp_last  = beat_is_last;
    end else if (!reset && (state_q == ST_LERR)) begin
      rsp_valid = 1'b1;
      rsp_error = 1'b1;
      rsp_last  = 1'b1;
    end
  end

  always_comb begin
    state_d        = state_q;
    op_opcode_d    = op_opcode_q;
    op_size_d      = op_size_q;
    op_address_d   = op_address_q;
    op_mask_d      = op_mask_q;
    op_data_d      = op_data_q;
    beat_cnt_d     = beat_cnt_q;
    tmo_cnt_d      = tmo_cnt_q;
    protocol_err_d = protocol_err_q;
    case (state_q)
      ST_IDLE: if (cmd_fire) begin
        op_opcode_d  = cmd_opcode;
        op_size_d    = cmd_size;
        op_address_d = cmd_address;
        op_mask_d    = cmd_mask;
        op_data_d    = cmd_data;
        state_d      = cmd_illegal ? ST_LERR : ST_REQ;
      end
      ST_REQ: if (a_fire) begin
        beat_cnt_d = 4'd0;
        tmo_cnt_d  = 8'd0;
        state_d    = ST_RESP;
      end
      ST_RESP: begin
        if (d_fire) begin
          tmo_cnt_d = 8'd0;
          if ((d_bits_source != SOURCE_ID) || (d_bits_opcode != exp_d_opcode)
              || (d_bits_size != op_size_q))
            protocol_err_d = 1'b1;
          if (beat_is_last) begin
            beat_cnt_d = 4'd0;
            state_d    = ST_IDLE;
          end else begin
            beat_cnt_d = beat_cnt_q + 4'd1;
          end
        end else if (tmo_cnt_q != TIMEOUT) begin
          tmo_cnt_d = tmo_cnt_q + 8'd1;
        end
        // Flag on the cycle the counter lands on TIMEOUT; the FSM keeps waiting.
        if (tmo_cnt_d == TIMEOUT) protocol_err_d = 1'b1;
      end
      ST_LERR: if (rsp_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (d_valid && (state_q != ST_RESP)) protocol_err_d = 1'b1;
  end

  assign protocol_err = protocol_err_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      op_opcode_q    <= A_GET;
      op_size_q      <= 3'd0;
      op_address_q   <= 32'd0;
      op_mask_q      <= '0;
      op_data_q      <= '0;
      beat_cnt_q     <= 4'd0;
      tmo_cnt_q      <= 8'd0;
      protocol_err_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      op_opcode_q    <= op_opcode_d;
      op_size_q      <= op_size_d;
      op_address_q   <= op_address_d;
      op_mask_q      <= op_mask_d;
      op_data_q      <= op_data_d;
      beat_cnt_q     <= beat_cnt_d;
      tmo_cnt_q      <= tmo_cnt_d;
      protocol_err_q <= protocol_err_d;
    end
  end

endmodule
